// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer: runs the instruction-memory handshake, picks the PC
// function select on retirement and counts retired instructions.
module pc_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             branch_req,
  input  logic             branch_cond,
  input  logic             branch_abs,
  input  logic             halt_req,
  output logic [1:0]       PS,
  output logic             imem_req,
  output logic             inst_valid,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, fetch wait counter and retired-instruction counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= 8'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Mealy outputs; wait counter only survives inside an unacked FETCH
  always_comb begin
    state_d    = state_q;
    wait_d     = 8'd0;
    cnt_d      = cnt_q;
    PS         = PS_HOLD;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack arriving on the final count still wins over the timeout
        if (imem_ack) begin
          state_d = ST_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_FETCH;
          wait_d  = wait_q + 8'd1;
        end
      end
      ST_EXEC: begin
        inst_valid = 1'b1;
        if (stall) begin
          state_d = ST_EXEC;
        end else if (halt_req) begin
          state_d = ST_HALT;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (branch_req && branch_cond) begin
          if (branch_abs) PS = PS_LOAD;
          else            PS = PS_REL;
          state_d = ST_FETCH;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          PS      = PS_INC;
          state_d = ST_FETCH;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) state_d = ST_FETCH;
        else       state_d = ST_HALT;
      end
      ST_ERROR: begin
        error   = 1'b1;
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instr_count = cnt_q;

endmodule
